priv_trap_ctrl: RTL and testbench

- Trap/return sequencer between the privilege exception/interrupt sources and the pipeline fetch redirect.
- Collects exceptions reported by the hazard unit and enabled machine interrupts, and picks one cause by fixed priority.
- Requests a pipeline flush, waits for the pipeline to report it is clear, then issues a one-cycle PC redirect and the CSR trap-write strobe.
- Also sequences MRET, redirecting fetch to mepc.

---
 rtl/machine_mode_types_pkg.sv | 76 +++++++
 rtl/priv_cause_encoder.sv | 60 ++++++
 rtl/priv_trap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_priv_trap_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_mode_types_pkg.sv
// Shared machine-mode trap types: cause codes, trap FSM states and the
// cause-encoder payload used by the trap sequencer.
package machine_mode_types_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_EXC = 9;
    localparam int unsigned NUM_INT = 3;
    localparam int unsigned CODE_W  = 5;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Exception vector bit positions; bit 0 is the highest priority
    localparam int unsigned EXC_B_FAULT_INSN = 0;
    localparam int unsigned EXC_B_MAL_INSN   = 1;
    localparam int unsigned EXC_B_ILLEGAL    = 2;
    localparam int unsigned EXC_B_BREAKPOINT = 3;
    localparam int unsigned EXC_B_ENV_M      = 4;
    localparam int unsigned EXC_B_MAL_S      = 5;
    localparam int unsigned EXC_B_MAL_L      = 6;
    localparam int unsigned EXC_B_FAULT_S    = 7;
    localparam int unsigned EXC_B_FAULT_L    = 8;

    // Interrupt vector bit positions, matching mie_bits {meie, mtie, msie}
    localparam int unsigned INT_B_MSI = 0;
    localparam int unsigned INT_B_MTI = 1;
    localparam int unsigned INT_B_MEI = 2;

    typedef enum logic [CODE_W-1:0] {
        EXC_INSN_MISALIGNED  = 5'd0,
        EXC_INSN_FAULT       = 5'd1,
        EXC_ILLEGAL_INSN     = 5'd2,
        EXC_BREAKPOINT       = 5'd3,
        EXC_LOAD_MISALIGNED  = 5'd4,
        EXC_LOAD_FAULT       = 5'd5,
        EXC_STORE_MISALIGNED = 5'd6,
        EXC_STORE_FAULT      = 5'd7,
        EXC_ECALL_M          = 5'd11
    } ex_cause_t;

    typedef enum logic [CODE_W-1:0] {
        INT_MSI = 5'd3,
        INT_MTI = 5'd7,
        INT_MEI = 5'd11
    } int_cause_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CLEAR,
        TRAP_REDIR,
        RET_REDIR
    } trap_fsm_t;

    localparam trap_fsm_t RESET_STATE = IDLE;

    typedef struct packed {
        logic              valid;
        logic              is_int;
        logic [CODE_W-1:0] code;
        logic              tval_sel;
    } cause_t;

    // Vectored mode offsets only interrupts; exceptions always go to base
    function automatic logic [XLEN-1:0] trap_target(
        input logic [XLEN-1:0]   mtvec,
        input logic              is_int,
        input logic [CODE_W-1:0] code
    );
        logic [XLEN-1:0] base;
        base = {mtvec[XLEN-1:2], 2'b00};
        if ((mtvec[1:0] == MTVEC_MODE_VECTORED) && is_int) begin
            return base + (XLEN'(code) << 2);
        end
        return base;
    endfunction

endpackage

// File: rtl/priv_cause_encoder.sv
// Fixed-priority trap cause selection: any exception beats any interrupt.
module priv_cause_encoder
    import machine_mode_types_pkg::*;
(
    input  logic [NUM_EXC-1:0] i_exc,
    input  logic [NUM_INT-1:0] i_int,
    output cause_t             o_cause_c
);

    always_comb begin
        o_cause_c = '0;
        if (i_exc[EXC_B_FAULT_INSN]) begin
            o_cause_c.valid    = 1'b1;
            o_cause_c.code     = EXC_INSN_FAULT;
            o_cause_c.tval_sel = 1'b1;
        end else if (i_exc[EXC_B_MAL_INSN]) begin
            o_cause_c.valid    = 1'b1;
            o_cause_c.code     = EXC_INSN_MISALIGNED;
            o_cause_c.tval_sel = 1'b1;
        end else if (i_exc[EXC_B_ILLEGAL]) begin
            o_cause_c.valid = 1'b1;
            o_cause_c.code  = EXC_ILLEGAL_INSN;
        end else if (i_exc[EXC_B_BREAKPOINT]) begin
            o_cause_c.valid = 1'b1;
            o_cause_c.code  = EXC_BREAKPOINT;
        end else if (i_exc[EXC_B_ENV_M]) begin
            o_cause_c.valid = 1'b1;
            o_cause_c.code  = EXC_ECALL_M;
        end else if (i_exc[EXC_B_MAL_S]) begin
            o_cause_c.valid    = 1'b1;
            o_cause_c.code     = EXC_STORE_MISALIGNED;
            o_cause_c.tval_sel = 1'b1;
        end else if (i_exc[EXC_B_MAL_L]) begin
            o_cause_c.valid    = 1'b1;
            o_cause_c.code     = EXC_LOAD_MISALIGNED;
            o_cause_c.tval_sel = 1'b1;
        end else if (i_exc[EXC_B_FAULT_S]) begin
            o_cause_c.valid    = 1'b1;
            o_cause_c.code     = EXC_STORE_FAULT;
            o_cause_c.tval_sel = 1'b1;
        end else if (i_exc[EXC_B_FAULT_L]) begin
            o_cause_c.valid    = 1'b1;
            o_cause_c.code     = EXC_LOAD_FAULT;
            o_cause_c.tval_sel = 1'b1;
        end else if (i_int[INT_B_MEI]) begin
            o_cause_c.valid  = 1'b1;
            o_cause_c.is_int = 1'b1;
            o_cause_c.code   = INT_MEI;
        end else if (i_int[INT_B_MSI]) begin
            o_cause_c.valid  = 1'b1;
            o_cause_c.is_int = 1'b1;
            o_cause_c.code   = INT_MSI;
        end else if (i_int[INT_B_MTI]) begin
            o_cause_c.valid  = 1'b1;
            o_cause_c.is_int = 1'b1;
            o_cause_c.code   = INT_MTI;
        end
    end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Trap/MRET sequencer: latches one cause, holds intr until the pipeline
// drains, then issues a single-cycle fetch redirect and CSR trap write.
module priv_trap_ctrl
    import machine_mode_types_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            fault_insn,
    input  logic            mal_insn,
    input  logic            illegal_insn,
    input  logic            breakpoint,
    input  logic            env_m,
    input  logic            mal_s,
    input  logic            mal_l,
    input  logic            fault_s,
    input  logic            fault_l,
    input  logic            timer_int,
    input  logic            soft_int,
    input  logic            ext_int,
    input  logic            mstatus_mie,
    input  logic [2:0]      mie_bits,
    input  logic            ret,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] badaddr,
    input  logic            pipe_clear,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_r,
    output logic            intr,
    output logic            insert_pc,
    output logic [XLEN-1:0] priv_pc,
    output logic            trap_wen,
    output logic [XLEN-1:0] mepc_w,
    output logic [XLEN-1:0] mcause_w,
    output logic [XLEN-1:0] mtval_w,
    output logic            mret_done
);

    logic [NUM_EXC-1:0] w_exc;
    logic [NUM_INT-1:0] w_ie_int;
    cause_t             w_cause;
    logic [XLEN-1:0]    w_tval;
    logic [XLEN-1:0]    w_target;

    assign w_exc    = {fault_l, fault_s, mal_l, mal_s, env_m,
                       breakpoint, illegal_insn, mal_insn, fault_insn};
    assign w_ie_int = {NUM_INT{mstatus_mie}} & mie_bits & {ext_int, timer_int, soft_int};

    priv_cause_encoder u_cause_enc (
        .i_exc     (w_exc),
        .i_int     (w_ie_int),
        .o_cause_c (w_cause)
    );

    assign w_tval   = w_cause.tval_sel ? badaddr : '0;
    assign w_target = trap_target(mtvec, w_cause.is_int, w_cause.code);

    trap_fsm_t         r_state;
    trap_fsm_t         w_state_nxt;
    logic              w_latch;

    logic              r_is_int;
    logic [CODE_W-1:0] r_code;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   r_tval;
    logic [XLEN-1:0]   r_target;

    logic              r_intr,      w_intr_nxt;
    logic              r_insert_pc, w_insert_pc_nxt;
    logic [XLEN-1:0]   r_priv_pc,   w_priv_pc_nxt;
    logic              r_trap_wen,  w_trap_wen_nxt;
    logic [XLEN-1:0]   r_mepc_w,    w_mepc_w_nxt;
    logic [XLEN-1:0]   r_mcause_w,  w_mcause_w_nxt;
    logic [XLEN-1:0]   r_mtval_w,   w_mtval_w_nxt;
    logic              r_mret_done, w_mret_done_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes default low; CSR data and redirect target hold between traps
    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_intr_nxt      = 1'b0;
        w_insert_pc_nxt = 1'b0;
        w_trap_wen_nxt  = 1'b0;
        w_mret_done_nxt = 1'b0;
        w_priv_pc_nxt   = r_priv_pc;
        w_mepc_w_nxt    = r_mepc_w;
        w_mcause_w_nxt  = r_mcause_w;
        w_mtval_w_nxt   = r_mtval_w;
        case (r_state)
            IDLE: begin
                if (w_cause.valid) begin
                    w_latch     = 1'b1;
                    w_intr_nxt  = 1'b1;
                    w_state_nxt = WAIT_CLEAR;
                end else if (ret) begin
                    w_priv_pc_nxt   = mepc_r;
                    w_insert_pc_nxt = 1'b1;
                    w_mret_done_nxt = 1'b1;
                    w_state_nxt     = RET_REDIR;
                end
            end
            WAIT_CLEAR: begin
                if (pipe_clear) begin
                    w_insert_pc_nxt = 1'b1;
                    w_trap_wen_nxt  = 1'b1;
                    w_priv_pc_nxt   = r_target;
                    w_mepc_w_nxt    = r_epc;
                    w_mcause_w_nxt  = {r_is_int, (XLEN - 1 - CODE_W)'(0), r_code};
                    w_mtval_w_nxt   = r_tval;
                    w_state_nxt     = TRAP_REDIR;
                end else begin
                    w_intr_nxt = 1'b1;
                end
            end
            TRAP_REDIR, RET_REDIR: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_intr      <= 1'b0;
            r_insert_pc <= 1'b0;
            r_priv_pc   <= '0;
            r_trap_wen  <= 1'b0;
            r_mepc_w    <= '0;
            r_mcause_w  <= '0;
            r_mtval_w   <= '0;
            r_mret_done <= 1'b0;
        end else begin
            r_intr      <= w_intr_nxt;
            r_insert_pc <= w_insert_pc_nxt;
            r_priv_pc   <= w_priv_pc_nxt;
            r_trap_wen  <= w_trap_wen_nxt;
            r_mepc_w    <= w_mepc_w_nxt;
            r_mcause_w  <= w_mcause_w_nxt;
            r_mtval_w   <= w_mtval_w_nxt;
            r_mret_done <= w_mret_done_nxt;
        end
    end

    // Cause snapshot taken on trap entry; sources are ignored afterwards
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_is_int <= 1'b0;
            r_code   <= '0;
            r_epc    <= '0;
            r_tval   <= '0;
            r_target <= '0;
        end else if (w_latch) begin
            r_is_int <= w_cause.is_int;
            r_code   <= w_cause.code;
            r_epc    <= epc;
            r_tval   <= w_tval;
            r_target <= w_target;
        end
    end

    assign intr      = r_intr;
    assign insert_pc = r_insert_pc;
    assign priv_pc   = r_priv_pc;
    assign trap_wen  = r_trap_wen;
    assign mepc_w    = r_mepc_w;
    assign mcause_w  = r_mcause_w;
    assign mtval_w   = r_mtval_w;
    assign mret_done = r_mret_done;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Directed and randomized trap/MRET sequences checked against a
// transaction-level model of cause priority, mtval and vector target.
module tb_priv_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
    logic        mal_s, mal_l, fault_s, fault_l;
    logic        timer_int, soft_int, ext_int, mstatus_mie;
    logic [2:0]  mie_bits;
    logic        ret, pipe_clear;
    logic [31:0] epc, badaddr, mtvec, mepc_r;
    logic        intr, insert_pc, trap_wen, mret_done;
    logic [31:0] priv_pc, mepc_w, mcause_w, mtval_w;

    int checks   = 0;
    int failures = 0;

    priv_trap_ctrl dut (
        .CLK(CLK), .RST(RST),
        .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
        .breakpoint(breakpoint), .env_m(env_m), .mal_s(mal_s), .mal_l(mal_l),
        .fault_s(fault_s), .fault_l(fault_l),
        .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
        .mstatus_mie(mstatus_mie), .mie_bits(mie_bits), .ret(ret),
        .epc(epc), .badaddr(badaddr), .pipe_clear(pipe_clear),
        .mtvec(mtvec), .mepc_r(mepc_r),
        .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc), .trap_wen(trap_wen),
        .mepc_w(mepc_w), .mcause_w(mcause_w), .mtval_w(mtval_w), .mret_done(mret_done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Exception table in priority order: fault_insn, mal_insn, illegal,
    // breakpoint, env_m, mal_s, mal_l, fault_s, fault_l
    function automatic int unsigned exc_code(input int i);
        case (i)
            0: return 1;  1: return 0;  2: return 2;  3: return 3;  4: return 11;
            5: return 6;  6: return 4;  7: return 7;  default: return 5;
        endcase
    endfunction

    function automatic bit exc_has_addr(input int i);
        return !(i == 2 || i == 3 || i == 4);
    endfunction

    // irq / mb bit layout is {ext, timer, soft}; interrupt priority ext > soft > timer
    function automatic void model(
        input  logic [8:0]  e,
        input  logic [2:0]  irq,
        input  logic        mie_g,
        input  logic [2:0]  mb,
        input  logic [31:0] tvec,
        input  logic [31:0] bad,
        output bit          v,
        output logic [31:0] cause,
        output logic [31:0] tval,
        output logic [31:0] tgt
    );
        logic [2:0]  q;
        int unsigned ibit, icode;
        q     = mie_g ? (irq & mb) : 3'b000;
        v     = 1'b0;
        cause = 32'd0;
        tval  = 32'd0;
        tgt   = tvec & 32'hFFFF_FFFC;
        for (int i = 0; i < 9; i++) begin
            if (e[i] && !v) begin
                v     = 1'b1;
                cause = exc_code(i);
                tval  = exc_has_addr(i) ? bad : 32'd0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            ibit  = (k == 0) ? 2 : (k == 1) ? 0 : 1;
            icode = (k == 0) ? 11 : (k == 1) ? 3 : 7;
            if (!v && q[ibit]) begin
                v     = 1'b1;
                cause = 32'h8000_0000 + icode;
                if (tvec[1:0] == 2'b01) tgt = tgt + icode * 4;
            end
        end
    endfunction

    task automatic set_src(input logic [8:0] e, input logic [2:0] irq);
        {fault_l, fault_s, mal_l, mal_s, env_m, breakpoint, illegal_insn, mal_insn, fault_insn} = e;
        {ext_int, timer_int, soft_int} = irq;
    endtask

    // One complete trap attempt: source pulse, wait_cyc cycles before
    // pipe_clear, redirect, then back to idle
    task automatic run_trap(
        input string       tag,
        input logic [8:0]  e,
        input logic [2:0]  irq,
        input logic        mie_g,
        input logic [2:0]  mb,
        input logic [31:0] tvec,
        input logic [31:0] bad,
        input logic [31:0] pc,
        input int          wait_cyc,
        input logic        with_ret
    );
        bit          v;
        logic [31:0] cause, tval, tgt;
        model(e, irq, mie_g, mb, tvec, bad, v, cause, tval, tgt);
        set_src(e, irq);
        mstatus_mie = mie_g;
        mie_bits    = mb;
        mtvec       = tvec;
        badaddr     = bad;
        epc         = pc;
        ret         = with_ret;
        pipe_clear  = 1'b0;
        tick();
        chk({tag, "_intr_rise"}, 32'(intr), 32'(v));
        chk({tag, "_no_mret"}, 32'(mret_done), 32'd0);
        set_src(9'd0, 3'd0);
        ret     = 1'b0;
        mtvec   = $urandom;
        badaddr = $urandom;
        epc     = $urandom;
        if (!v) begin
            tick();
            chk({tag, "_idle_intr"}, 32'(intr), 32'd0);
            chk({tag, "_idle_insert"}, 32'(insert_pc), 32'd0);
            return;
        end
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            chk({tag, "_hold_intr"}, 32'(intr), 32'd1);
            chk({tag, "_hold_insert"}, 32'(insert_pc), 32'd0);
        end
        pipe_clear = 1'b1;
        tick();
        chk({tag, "_insert"}, 32'(insert_pc), 32'd1);
        chk({tag, "_trap_wen"}, 32'(trap_wen), 32'd1);
        chk({tag, "_intr_fall"}, 32'(intr), 32'd0);
        chk({tag, "_priv_pc"}, priv_pc, tgt);
        chk({tag, "_mcause"}, mcause_w, cause);
        chk({tag, "_mepc"}, mepc_w, pc);
        chk({tag, "_mtval"}, mtval_w, tval);
        chk({tag, "_mret"}, 32'(mret_done), 32'd0);
        pipe_clear = 1'b0;
        tick();
        chk({tag, "_strobe_clr"}, 32'({insert_pc, trap_wen, intr}), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        set_src(9'd0, 3'd0);
        mstatus_mie = 1'b0; mie_bits = 3'd0; ret = 1'b0; pipe_clear = 1'b0;
        epc = '0; badaddr = '0; mtvec = '0; mepc_r = '0;
        tick();
        tick();
        chk("rst_strobes", 32'({intr, insert_pc, trap_wen, mret_done}), 32'd0);
        chk("rst_priv_pc", priv_pc, 32'd0);
        chk("rst_csr", mepc_w | mcause_w | mtval_w, 32'd0);
        RST = 1'b0;

        pipe_clear = 1'b1;
        tick();
        chk("idle_pipe_clear", 32'({intr, insert_pc, trap_wen}), 32'd0);
        pipe_clear = 1'b0;

        run_trap("mal_l", 9'b0_0100_0000, 3'b000, 1'b0, 3'b000, 32'h100, 32'h1003, 32'h200, 3, 1'b0);
        run_trap("timer_vec", 9'd0, 3'b010, 1'b1, 3'b010, 32'h101, 32'hDEAD, 32'h300, 1, 1'b0);
        run_trap("timer_off", 9'd0, 3'b010, 1'b0, 3'b010, 32'h101, 32'hDEAD, 32'h300, 1, 1'b0);
        run_trap("ill_ext_ret", 9'b0_0000_0100, 3'b100, 1'b1, 3'b111, 32'h105, 32'h44, 32'h88, 1, 1'b1);
        run_trap("ext_pulse", 9'd0, 3'b100, 1'b1, 3'b100, 32'h401, 32'h0, 32'h1234, 5, 1'b0);
        run_trap("min_lat", 9'b0_0000_0001, 3'b111, 1'b1, 3'b111, 32'hFFFF_FFFD, 32'hABC, 32'h40, 0, 1'b0);

        // MRET redirect
        ret = 1'b1; mepc_r = 32'h0000_0480;
        tick();
        chk("ret_insert", 32'(insert_pc), 32'd1);
        chk("ret_priv_pc", priv_pc, 32'h480);
        chk("ret_done", 32'(mret_done), 32'd1);
        chk("ret_no_wen", 32'(trap_wen), 32'd0);
        ret = 1'b0;
        tick();
        chk("ret_clr", 32'({insert_pc, mret_done}), 32'd0);

        // Held interrupt retriggers one cycle after the redirect
        mstatus_mie = 1'b1; mie_bits = 3'b010; timer_int = 1'b1; mtvec = 32'h200; epc = 32'h500;
        tick();
        chk("b2b_intr", 32'(intr), 32'd1);
        pipe_clear = 1'b1;
        tick();
        chk("b2b_insert", 32'(insert_pc), 32'd1);
        chk("b2b_mcause", mcause_w, 32'h8000_0007);
        pipe_clear = 1'b0;
        tick();
        chk("b2b_gap", 32'({intr, insert_pc}), 32'd0);
        tick();
        chk("b2b_retrigger", 32'(intr), 32'd1);
        timer_int = 1'b0;
        pipe_clear = 1'b1;
        tick();
        chk("b2b_insert2", 32'(insert_pc), 32'd1);
        pipe_clear = 1'b0;
        tick();

        // Reset while waiting for the pipeline abandons the trap
        env_m = 1'b1;
        tick();
        chk("rstw_intr", 32'(intr), 32'd1);
        env_m = 1'b0;
        RST = 1'b1;
        tick();
        chk("rstw_strobes", 32'({intr, insert_pc, trap_wen, mret_done}), 32'd0);
        chk("rstw_priv_pc", priv_pc, 32'd0);
        chk("rstw_mcause", mcause_w, 32'd0);
        RST = 1'b0;
        pipe_clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstw_no_redirect", 32'({intr, insert_pc, trap_wen}), 32'd0);
        end
        pipe_clear = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [8:0] e;
            e = 9'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) e = 9'd0;
            run_trap("rnd", e, 3'($urandom), 1'($urandom), 3'($urandom),
                     $urandom, $urandom, $urandom, int'($urandom_range(0, 4)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
